// File: rtl/im_param.sv
`default_nettype none
// ============================================================================
// Module   : im_param
// Brief    : Parametrised synchronous instruction memory for the fetch stage.
//            The block writes a boot image into the array after reset.
//            Fetches use a request/valid handshake with one-cycle latency.
//            A load port writes the array at run time.
// Revision : 1.0 - initial release
// ============================================================================
module im_param #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32   // 4 <= DEPTH <= 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  output logic [WIDTH-1:0]  instr,
  output logic              instr_valid,
  output logic              pc_err,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              ld_ack,
  output logic              ld_err
);

  // Array index width. Because DEPTH <= 2**ADDR_W, IDX_W never exceeds ADDR_W.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH is held one bit wider than an address so that DEPTH == 2**ADDR_W
  // fits, and the range checks then always pass.
  localparam logic [ADDR_W:0]   c_DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  init_ptr_q, init_ptr_d;
  logic [WIDTH-1:0]   instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               pc_err_q, pc_err_d;
  logic               ld_ack_q, ld_ack_d;
  logic               ld_err_q, ld_err_d;

  logic [WIDTH-1:0]   mem_q [DEPTH];

  // The init sequencer and the load port share one write port.
  // The two never compete, because the load port is only honoured in READY.
  logic               w_wr_en;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [WIDTH-1:0]   w_wr_data;

  logic               w_pc_in_range;
  logic               w_ld_in_range;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]   w_ld_idx;
  logic [WIDTH-1:0]   w_rd_word;

  // The boot image is given as 32-bit words. It is then zero-extended or
  // truncated to WIDTH.
  function automatic logic [WIDTH-1:0] boot_word(input logic [ADDR_W-1:0] a);
    logic [31:0] v;
    v = 32'h0000_0000;
    if (a == ADDR_W'(0)) v = 32'h0000_0200;
    if (a == ADDR_W'(1)) v = 32'h0000_0201;
    if (a == ADDR_W'(2)) v = 32'h0000_0204;
    if (a == ADDR_W'(3)) v = 32'h0000_0108;
    return WIDTH'(v);
  endfunction

  // Decode the address ranges and read the array. When an address is out of
  // range, the mux after the read discards the word.
  always_comb begin
    w_pc_in_range = ({1'b0, pc} < c_DEPTH_EXT);
    w_ld_in_range = ({1'b0, ld_addr} < c_DEPTH_EXT);
    w_rd_idx      = pc[IDX_W-1:0];
    w_ld_idx      = ld_addr[IDX_W-1:0];
    w_rd_word     = mem_q[w_rd_idx];
  end

  // Next-state logic, output pulses and write-port steering.
  always_comb begin
    state_d       = state_q;
    init_ptr_d    = init_ptr_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    pc_err_d      = 1'b0;
    ld_ack_d      = 1'b0;
    ld_err_d      = 1'b0;
    w_wr_en       = 1'b0;
    w_wr_idx      = init_ptr_q[IDX_W-1:0];
    w_wr_data     = boot_word(init_ptr_q);

    unique case (state_q)
      ST_INIT: begin
        // Write one boot word per cycle. Fetch and load requests are ignored.
        w_wr_en    = 1'b1;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == c_LAST_IDX) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (fetch_req) begin
          instr_valid_d = 1'b1;
          pc_err_d      = ~w_pc_in_range;
          instr_d       = w_pc_in_range ? w_rd_word : '0;
        end
        if (ld_en) begin
          if (w_ld_in_range) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = w_ld_idx;
            w_wr_data = ld_data;
            ld_ack_d  = 1'b1;
          end else begin
            ld_err_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_ptr_d = '0;
      end
    endcase
  end

  // State and output registers. Reset has priority over every request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      init_ptr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_err_q      <= 1'b0;
      ld_ack_q      <= 1'b0;
      ld_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_err_q      <= pc_err_d;
      ld_ack_q      <= ld_ack_d;
      ld_err_q      <= ld_err_d;
    end
  end

  // Array write port. The fetch above reads the old word in the same edge,
  // so a fetch and a load to one address see the value before the write.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      mem_q[w_wr_idx] <= w_wr_data;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc_err      = pc_err_q;
  assign ld_ack      = ld_ack_q;
  assign ld_err      = ld_err_q;
  assign busy        = (state_q == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_im_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_param
// Brief    : Self-checking bench for im_param. It instantiates DEPTH=32 and
//            DEPTH=24 copies of the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_param;

  logic        clk = 1'b0;
  logic        reset;

  // DEPTH=32 instance
  logic [4:0]  pc, ld_addr;
  logic        fetch_req, ld_en;
  logic [31:0] ld_data, instr;
  logic        instr_valid, pc_err, busy, ld_ack, ld_err;

  // DEPTH=24 instance
  logic [4:0]  pc24, ld_addr24;
  logic        fetch24, ld_en24;
  logic [31:0] ld_data24, instr24;
  logic        valid24, pc_err24, busy24, ld_ack24, ld_err24;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  im_param #(.WIDTH(32), .ADDR_W(5), .DEPTH(32)) dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req),
    .instr(instr), .instr_valid(instr_valid), .pc_err(pc_err), .busy(busy),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ack(ld_ack), .ld_err(ld_err)
  );

  im_param #(.WIDTH(32), .ADDR_W(5), .DEPTH(24)) dut24 (
    .clk(clk), .reset(reset), .pc(pc24), .fetch_req(fetch24),
    .instr(instr24), .instr_valid(valid24), .pc_err(pc_err24), .busy(busy24),
    .ld_en(ld_en24), .ld_addr(ld_addr24), .ld_data(ld_data24),
    .ld_ack(ld_ack24), .ld_err(ld_err24)
  );

  typedef struct {
    logic        fetch;
    logic [4:0]  pc;
    logic        ld;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic        exp_pc_err;
    logic        exp_ack;
    logic        exp_ld_err;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Counts the samples in which busy is high, starting at the current sample.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic fetch32(input logic [4:0] a, input logic [31:0] exp, input string nm);
    pc = a; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check({nm, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check({nm, "_instr"}, instr, exp);
  endtask

  task automatic pulse_reset(input string nm);
    reset = 1'b1; fetch_req = 1'b1; pc = 5'd0;
    tick();
    reset = 1'b0; fetch_req = 1'b0;
    check({nm, "_busy"},  {31'b0, busy}, 32'd1);
    check({nm, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check({nm, "_instr"}, instr, 32'd0);
  endtask

  initial begin
    int n, n24, bad;

    reset = 1'b1;
    fetch_req = 1'b0; pc = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    fetch24 = 1'b0; pc24 = '0; ld_en24 = 1'b0; ld_addr24 = '0; ld_data24 = '0;

    // Fetches 0..4, then a load, a fetch with the same-address load, and the top word.
    vecs[0]  = '{1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd1,  1'b0, 5'd0,  32'h0,        1'b1, 32'h0000_0201, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd2,  1'b0, 5'd0,  32'h0,        1'b1, 32'h0000_0204, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        1'b1, 32'h0000_0108, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd4,  1'b0, 5'd0,  32'h0,        1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'd1,  1'b1, 5'd1,  32'h12345678, 1'b1, 32'h0000_0201, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 5'd1,  1'b0, 5'd0,  32'h0,        1'b1, 32'h12345678,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd2,  1'b0, 5'd0,  32'h0,        1'b0, 32'h12345678,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 32'h12345678,  1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 5'd31, 1'b0, 5'd0,  32'h0,        1'b1, 32'hA5A5A5A5,  1'b0, 1'b0, 1'b0};

    // Reset for two cycles and check the reset state.
    tick(); tick();
    check("rst_busy",   {31'b0, busy}, 32'd1);
    check("rst_instr",  instr, 32'd0);
    check("rst_valid",  {31'b0, instr_valid}, 32'd0);
    check("rst_pc_err", {31'b0, pc_err}, 32'd0);
    check("rst_ack",    {31'b0, ld_ack}, 32'd0);
    check("rst_ld_err", {31'b0, ld_err}, 32'd0);

    // Release reset. Hold fetch and load requests high through INIT; they must be ignored.
    reset = 1'b0;
    fetch_req = 1'b1; pc = 5'd3; ld_en = 1'b1; ld_addr = 5'd3; ld_data = 32'h0000_0BAD;
    n = 0; n24 = 0; bad = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (busy24 === 1'b1) n24++;
      tick();
      if (instr_valid !== 1'b0 || ld_ack !== 1'b0 || ld_err !== 1'b0 || pc_err !== 1'b0) bad++;
    end
    fetch_req = 1'b0; ld_en = 1'b0;
    check("init_busy_cycles",   n,   32'd32);
    check("init24_busy_cycles", n24, 32'd24);
    check("init_ignored_pulses", bad, 32'd0);

    // Table of vectors applied in READY.
    for (int i = 0; i < 12; i++) begin
      fetch_req = vecs[i].fetch; pc = vecs[i].pc;
      ld_en = vecs[i].ld; ld_addr = vecs[i].ld_addr; ld_data = vecs[i].ld_data;
      tick();
      check($sformatf("vec%0d_valid", i),  {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_instr", i),  instr, vecs[i].exp_instr);
      check($sformatf("vec%0d_pc_err", i), {31'b0, pc_err}, {31'b0, vecs[i].exp_pc_err});
      check($sformatf("vec%0d_ack", i),    {31'b0, ld_ack}, {31'b0, vecs[i].exp_ack});
      check($sformatf("vec%0d_ld_err", i), {31'b0, ld_err}, {31'b0, vecs[i].exp_ld_err});
    end
    fetch_req = 1'b0; ld_en = 1'b0;

    // DEPTH=24: out-of-range fetches and loads, plus the boundary addresses.
    pc24 = 5'd30; fetch24 = 1'b1;
    tick();
    fetch24 = 1'b0;
    check("d24_pc30_valid", {31'b0, valid24}, 32'd1);
    check("d24_pc30_instr", instr24, 32'd0);
    check("d24_pc30_err",   {31'b0, pc_err24}, 32'd1);
    ld_en24 = 1'b1; ld_addr24 = 5'd25; ld_data24 = 32'hCAFEF00D;
    tick();
    ld_en24 = 1'b0;
    check("d24_ld25_err", {31'b0, ld_err24}, 32'd1);
    check("d24_ld25_ack", {31'b0, ld_ack24}, 32'd0);
    pc24 = 5'd23; fetch24 = 1'b1;
    tick();
    check("d24_pc23_instr", instr24, 32'd0);
    check("d24_pc23_err",   {31'b0, pc_err24}, 32'd0);
    pc24 = 5'd24;
    tick();
    check("d24_pc24_err",   {31'b0, pc_err24}, 32'd1);
    pc24 = 5'd3;
    tick();
    fetch24 = 1'b0;
    check("d24_pc3_instr",  instr24, 32'h0000_0108);
    check("d24_pc3_err",    {31'b0, pc_err24}, 32'd0);
    ld_en24 = 1'b1; ld_addr24 = 5'd23; ld_data24 = 32'h0000_5555;
    tick();
    ld_en24 = 1'b0;
    check("d24_ld23_ack", {31'b0, ld_ack24}, 32'd1);
    check("d24_ld23_err", {31'b0, ld_err24}, 32'd0);

    // Load word 0, then reset from READY; the boot image must come back.
    ld_en = 1'b1; ld_addr = 5'd0; ld_data = 32'hFFFF_FFFF;
    tick();
    ld_en = 1'b0;
    check("ld0_ack", {31'b0, ld_ack}, 32'd1);
    fetch32(5'd0, 32'hFFFF_FFFF, "pc0_loaded");
    pulse_reset("rstA");
    count_busy(n);
    check("rstA_busy_cycles", n, 32'd32);
    fetch32(5'd0, 32'h0000_0200, "rstA_pc0");
    fetch32(5'd7, 32'h0000_0000, "rstA_pc7");

    // Reset in the middle of INIT restarts the full sequence.
    pulse_reset("rstB");
    for (int k = 0; k < 10; k++) tick();
    check("midinit_busy", {31'b0, busy}, 32'd1);
    pulse_reset("rstC");
    count_busy(n);
    check("rstC_busy_cycles", n, 32'd32);
    fetch32(5'd0, 32'h0000_0200, "rstC_pc0");
    fetch32(5'd3, 32'h0000_0108, "rstC_pc3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/im_param.md
Name: im_param

Overview:
Parametrised synchronous instruction memory; next generation of the single-cycle instruction memory feeding the fetch stage of the lab CPU datapath. Width and depth are parametrised and every access is clocked. After reset, a self-initialisation sequencer writes the boot image into the array, and a load port lets the testbench or a loader program the array at run time. Fetches use a request/valid handshake with one-cycle latency and an out-of-range error flag.

Parameters:
WIDTH, 32, instruction word width in bits
ADDR_W, 5, width of pc and ld_addr
DEPTH, 32, number of words; must satisfy 4 <= DEPTH <= 2^ADDR_W

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-high
pc  in  ADDR_W  fetch address (word index)
fetch_req  in  1  fetch request, sampled at rising edge
instr  out  WIDTH  fetched instruction word
instr_valid  out  1  one-cycle pulse: instr updated by a fetch
pc_err  out  1  one-cycle pulse alongside instr_valid when pc >= DEPTH
busy  out  1  high while the boot image is being written
ld_en  in  1  load-port write enable
ld_addr  in  ADDR_W  load-port word address
ld_data  in  WIDTH  load-port write data
ld_ack  out  1  one-cycle pulse: load write committed
ld_err  out  1  one-cycle pulse: load rejected because ld_addr >= DEPTH

Behaviour:
- Only one clock exists. reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- On reset, the next state is INIT with init_ptr=0. Outputs reset to instr=0, instr_valid=0, pc_err=0, ld_ack=0, ld_err=0, busy=1. Reset has priority over all other inputs.
- Boot image:
  - word0=0x00000200
  - word1=0x00000201
  - word2=0x00000204
  - word3=0x00000108
  - all other words=0
  - Each value is zero-extended or truncated to WIDTH.
- The state machine has two states, INIT and READY.
  - INIT: each cycle writes mem[init_ptr]=boot(init_ptr), then increments init_ptr. In the cycle that writes DEPTH-1, the next state is READY.
  - busy=1 throughout INIT. INIT lasts exactly DEPTH cycles after the first cycle with reset low.
  - In INIT, fetch_req and ld_en are ignored: no write, no pulses.
  - READY: busy=0. The block stays in READY until reset.
- Fetch (READY only):
  - fetch_req=1 at edge N gives, at edge N+1, instr_valid=1 and instr=mem[pc sampled at N].
  - If pc>=DEPTH, instr=0 and pc_err=1.
  - Back-to-back requests each get a pulse (throughput 1/cycle).
  - Without a request, instr_valid=0 and pc_err=0, and instr holds its last value.
- Load (READY only):
  - ld_en=1 with ld_addr<DEPTH writes mem[ld_addr]=ld_data at that edge; ld_ack=1 the following cycle.
  - ld_addr>=DEPTH: no write; ld_err=1 the following cycle, ld_ack=0.
- Fetch and load in the same cycle to the same address: the read returns the old word (read-before-write). A later fetch returns the new word. Different addresses proceed independently.
- Reset mid-INIT restarts from init_ptr=0.
- Reset in READY discards all loaded contents: the boot image is rewritten during the new INIT.
- A request accepted in the cycle reset asserts produces no pulse.
- Reset held high for multiple cycles keeps INIT with init_ptr=0 and busy=1.
- When DEPTH=2^ADDR_W, pc_err and ld_err can never assert.

Test Plan:
1. Reset 2 cycles, then release. Required: busy=1 for exactly 32 cycles, then 0. Fetch pc=0..4 back-to-back gives instr=0x200, 0x201, 0x204, 0x108, 0x0, each with instr_valid the cycle after its request and pc_err=0.
2. Assert fetch_req and ld_en during INIT. Required: no instr_valid, no ld_ack, no write. After READY, a fetch of pc=3 returns 0x108.
3. In READY, load addr 7 = 0xDEADBEEF. Required: ld_ack one cycle later. Then fetch pc=7 returns 0xDEADBEEF.
4. Same cycle: fetch pc=1 and load addr 1 = 0x12345678. Required: instr=0x201. The next fetch of pc=1 returns 0x12345678.
5. With DEPTH=24 and ADDR_W=5: fetch pc=30 gives instr=0, instr_valid=1, pc_err=1. Load addr 25 gives ld_err=1, ld_ack=0, and the memory is unchanged.
6. Load addr 0 = 0xFFFFFFFF, then assert reset for 1 cycle mid-run, also once mid-INIT. Required: busy=1 for a full 32 cycles after each release, and a fetch of pc=0 returns 0x200.
